// File: rtl/pipeline_control_unit.sv
// Pipeline control: turns hazard, branch, miss and exception inputs into per-stage
// stall/kill strobes, fetch redirects, a registered load-to-use replay select and perf counters.
module pipeline_control_unit #(
  parameter int unsigned     XLEN             = 32,
  parameter logic [XLEN-1:0] TRAP_VECTOR      = 32'h0000_2000,
  parameter int unsigned     EXC_FLUSH_CYCLES = 2,
  parameter int unsigned     CNT_WIDTH        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_to_use_hazard,
  input  logic                 ltu_dep_src1,
  input  logic                 ltu_dep_src2,
  input  logic                 branch_taken_exe,
  input  logic [XLEN-1:0]      branch_target_exe,
  input  logic                 fetch_busy,
  input  logic                 mem_busy,
  input  logic                 exc_valid_mem,
  output logic                 stall_fetch,
  output logic                 stall_dec,
  output logic                 stall_exe,
  output logic                 stall_mem,
  output logic                 kill_fetch,
  output logic                 kill_dec,
  output logic                 kill_exe,
  output logic                 kill_mem,
  output logic                 kill_wb,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 ltu_replay_src1,
  output logic                 ltu_replay_src2,
  output logic [CNT_WIDTH-1:0] stall_cycle_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  typedef enum logic [0:0] {StRun, StExcFlush} state_e;

  localparam logic [3:0] FlushLoad = 4'(EXC_FLUSH_CYCLES);

  state_e                 state_q, state_d;
  logic [3:0]             left_q, left_d;
  logic                   rep1_q, rep1_d;
  logic                   rep2_q, rep2_d;
  logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]   flush_cnt_q, flush_cnt_d;

  // Stage index: 0 fetch, 1 decode, 2 execute, 3 memory, 4 writeback.
  logic [3:0]             stall_c;
  logic [4:0]             kill_c;
  logic                   redir_c;
  logic [XLEN-1:0]        redir_pc_c;

  always_comb begin
    stall_c    = '0;
    kill_c     = '0;
    redir_c    = 1'b0;
    redir_pc_c = '0;
    state_d    = state_q;
    left_d     = left_q;
    rep1_d     = rep1_q;
    rep2_d     = rep2_q;

    if (exc_valid_mem) begin
      // Older instruction in writeback still retires.
      kill_c[3:0] = 4'b1111;
      redir_c     = 1'b1;
      redir_pc_c  = TRAP_VECTOR;
      rep1_d      = 1'b0;
      rep2_d      = 1'b0;
      left_d      = FlushLoad;
      state_d     = StExcFlush;
    end else begin
      unique case (state_q)
        StRun: begin
          if (mem_busy) begin
            stall_c   = 4'b1111;
            kill_c[4] = 1'b1;
          end else if (branch_taken_exe) begin
            kill_c[1:0] = 2'b11;
            redir_c     = 1'b1;
            redir_pc_c  = branch_target_exe;
            rep1_d      = 1'b0;
            rep2_d      = 1'b0;
          end else if (load_to_use_hazard) begin
            stall_c[1:0] = 2'b11;
            kill_c[2]    = 1'b1;
            rep1_d       = ltu_dep_src1;
            rep2_d       = ltu_dep_src2;
          end else begin
            // Pipeline advances: any pending replay is consumed this cycle.
            rep1_d = 1'b0;
            rep2_d = 1'b0;
            if (fetch_busy) begin
              stall_c[0] = 1'b1;
              kill_c[1]  = 1'b1;
            end
          end
        end
        StExcFlush: begin
          stall_c[0] = 1'b1;
          if (mem_busy) begin
            // Decode already holds a bubble; holding it keeps stall and kill exclusive.
            stall_c[3:1] = 3'b111;
            kill_c[4]    = 1'b1;
          end else begin
            kill_c[1] = 1'b1;
            rep1_d    = 1'b0;
            rep2_d    = 1'b0;
          end
          if (left_q <= 4'd1) begin
            state_d = StRun;
          end else begin
            left_d = left_q - 4'd1;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  // Combinational strobes are forced low while reset is asserted.
  assign stall_fetch    = rst & stall_c[0];
  assign stall_dec      = rst & stall_c[1];
  assign stall_exe      = rst & stall_c[2];
  assign stall_mem      = rst & stall_c[3];
  assign kill_fetch     = rst & kill_c[0];
  assign kill_dec       = rst & kill_c[1];
  assign kill_exe       = rst & kill_c[2];
  assign kill_mem       = rst & kill_c[3];
  assign kill_wb        = rst & kill_c[4];
  assign redirect_valid = rst & redir_c;
  assign redirect_pc    = (rst && redir_c) ? redir_pc_c : '0;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_dec && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
    if (redirect_valid && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StRun;
      left_q      <= '0;
      rep1_q      <= 1'b0;
      rep2_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      left_q      <= left_d;
      rep1_q      <= rep1_d;
      rep2_q      <= rep2_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ltu_replay_src1 = rep1_q;
  assign ltu_replay_src2 = rep2_q;
  assign stall_cycle_cnt = stall_cnt_q;
  assign flush_cnt       = flush_cnt_q;

`ifndef SYNTHESIS
  a_dec_excl: assert property (@(posedge clk) disable iff (!rst) !(stall_dec && kill_dec));
  a_exe_excl: assert property (@(posedge clk) disable iff (!rst) !(stall_exe && kill_exe));
  a_mem_excl: assert property (@(posedge clk) disable iff (!rst) !(stall_mem && kill_mem));
  a_left_nz:  assert property (@(posedge clk) disable iff (!rst)
                               (state_q == StExcFlush) |-> (left_q != 4'd0));
`endif

endmodule

// File: doc/pipeline_control_unit.md
Name: pipeline_control_unit

Overview:
- Consumer side of the hazard detection path: takes the load-to-use stall request and dependency flags, branch resolution, cache-busy and exception inputs.
- Turns them into per-stage stall (hold) and kill (bubble) strobes, fetch redirects and a registered replay-bypass select for the decode stage.
- Drives the kill_* lines the hazard detector leaves undriven.
- Sits beside the hazard module in the core top and fans out to fetch, decode, execute, memory and the decode-side writeback port.

Parameters:
- XLEN, 32: PC width.
- TRAP_VECTOR, 32'h0000_2000: redirect PC on exception.
- EXC_FLUSH_CYCLES, 2: cycles fetch is held after an exception redirect (1..15).
- CNT_WIDTH, 32: width of the performance counters.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- load_to_use_hazard  in  1  stall request from the hazard module.
- ltu_dep_src1, ltu_dep_src2  in  1  load-to-use dependency flags per source operand.
- branch_taken_exe  in  1  taken branch/jump resolved in execute.
- branch_target_exe  in  XLEN  target of that branch.
- fetch_busy  in  1  I-side miss pending.
- mem_busy  in  1  D-side miss pending for the instruction in memory.
- exc_valid_mem  in  1  exception raised by the instruction in memory.
- stall_fetch, stall_dec, stall_exe, stall_mem  out  1  hold the stage register.
- kill_fetch, kill_dec, kill_exe, kill_mem, kill_wb  out  1  load a bubble (valid=0) into the stage register.
- redirect_valid  out  1  one-cycle fetch PC redirect.
- redirect_pc  out  XLEN  redirect target.
- ltu_replay_src1, ltu_replay_src2  out  1  decode selects the memory-stage bypass for that operand.
- stall_cycle_cnt  out  CNT_WIDTH  cycles with stall_dec=1.
- flush_cnt  out  CNT_WIDTH  redirects issued.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0, state=RUN, flush counter 0.
  - ltu replay registers 0; both performance counters 0.
  - Applies immediately mid-operation.
- Stall/kill/redirect outputs are combinational from inputs and state. Replay, state and counters are registered.
- FSM states: RUN, EXC_FLUSH.
- RUN, fixed priority, first match wins:
  1. exc_valid_mem:
     - kill_fetch/dec/exe/mem=1, kill_wb=0 (older instruction completes).
     - redirect_valid=1, redirect_pc=TRAP_VECTOR.
     - Clear replay regs; load flush counter with EXC_FLUSH_CYCLES; next state EXC_FLUSH.
  2. mem_busy:
     - stall_fetch/dec/exe/mem=1, kill_wb=1.
     - No redirect; branch_taken_exe and load_to_use_hazard are ignored and re-evaluated when the pipeline advances.
     - Replay regs hold their value.
  3. branch_taken_exe:
     - kill_fetch=1, kill_dec=1, redirect_valid=1, redirect_pc=branch_target_exe.
     - Replay regs cleared, because the dependent instruction is killed.
  4. load_to_use_hazard:
     - stall_fetch=1, stall_dec=1, kill_exe=1 (one bubble).
     - Next cycle ltu_replay_src1/2 = registered ltu_dep_src1/2.
  5. fetch_busy: stall_fetch=1, kill_dec=1.
  6. Otherwise all strobes 0.
- Replay lifetime:
  - ltu_replay_* is high for exactly one advancing cycle: the cycle after the bubble, or later if mem_busy intervenes.
  - It is cleared on the first cycle with mem_busy=0.
- EXC_FLUSH:
  - stall_fetch=1, kill_dec=1.
  - Branch and ltu are ignored; mem_busy still adds stall_dec/exe/mem and kill_wb.
  - A new exc_valid_mem behaves as in RUN: redirect again and reload the counter.
  - The counter decrements each cycle; at 1, the next state is RUN.
- Invariants:
  - A stage is never both stalled and killed, except kill_fetch with stall_fetch, where kill wins.
  - redirect_valid is never high in two consecutive cycles from the same branch.
- Counters:
  - stall_cycle_cnt and flush_cnt saturate at 2^CNT_WIDTH-1.
  - flush_cnt increments on each redirect_valid.

Test Plan:
- Reset: hold rst=0 with all inputs toggling -> every output 0; release -> state RUN, counters 0.
- Load-to-use: load_to_use_hazard=1 with ltu_dep_src2=1 for 1 cycle -> that cycle stall_fetch=stall_dec=kill_exe=1; next cycle ltu_replay_src2=1 and ltu_replay_src1=0; following cycle both 0; stall_cycle_cnt=1.
- Miss during replay: ltu cycle, then mem_busy=1 for 3 cycles -> stall_fetch..mem=1 and kill_wb=1 for 3 cycles with ltu_replay_src2 held; it is seen once on the first non-busy cycle; stall_cycle_cnt=4.
- Branch vs ltu: branch_taken_exe=1, target 32'h0000_0100, same cycle as load_to_use_hazard -> kill_fetch=kill_dec=1, redirect_pc=32'h100, no kill_exe, no replay next cycle; flush_cnt=1.
- Exception vs branch: exc_valid_mem=1 with branch_taken_exe=1 -> redirect_pc=32'h2000, kill_fetch..mem=1, kill_wb=0; then 2 cycles of stall_fetch=1 with kill_dec=1, ignoring a branch pulse; RUN on cycle 3.
- Saturation: CNT_WIDTH=4, 20 consecutive mem_busy cycles -> stall_cycle_cnt stops at 15.
